// File: rtl/codificador_hamming_tx_if.sv
// Purpose: bundles the nibble-in / codeword-out signals of the Hamming(8,4) transmitter.
// Latency: n/a (wiring only).
// Backpressure: listo_out is the ready signal; valido_in is ignored while it is low.
// Ports:
//   datos_in[3:0], valido_in, mascara_error[7:0]     -> driven by the producer (master)
//   listo_out, palabra_out[7:0], palabra_valida,
//   tx_serial, tx_activo, hecho                     -> driven by the encoder (slave)
interface codificador_hamming_tx_if;
  logic [3:0] datos_in;
  logic       valido_in;
  logic [7:0] mascara_error;
  logic       listo_out;
  logic [7:0] palabra_out;
  logic       palabra_valida;
  logic       tx_serial;
  logic       tx_activo;
  logic       hecho;

  modport master (
    output datos_in, valido_in, mascara_error,
    input  listo_out, palabra_out, palabra_valida, tx_serial, tx_activo, hecho
  );

  modport slave (
    input  datos_in, valido_in, mascara_error,
    output listo_out, palabra_out, palabra_valida, tx_serial, tx_activo, hecho
  );
endinterface

// File: rtl/codificador_hamming_tx.sv
// Purpose: SECDED Hamming(8,4) encoder with error-mask injection and LSB-first serialiser.
// Latency: codeword registered 1 edge after acceptance; first serial bit 2 edges after; one word per 11 cycles.
// Backpressure: listo_out high only in IDLE; valido_in is ignored (not queued) while busy.
// Ports:
//   clk, rst            : clock and synchronous active-high reset
//   bus (slave modport) : datos_in/valido_in/mascara_error in; listo_out, palabra_out,
//                         palabra_valida, tx_serial, tx_activo, hecho out
module codificador_hamming_tx (
  input  logic                      clk,
  input  logic                      rst,
  codificador_hamming_tx_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CODIFICA  = 2'd1,
    TRANSMITE = 2'd2,
    FIN       = 2'd3
  } estado_t;

  // Word captured at acceptance; stays stable while the FSM is busy.
  typedef struct packed {
    logic [3:0] datos;
    logic [7:0] mascara;
  } captura_t;

  estado_t    estado, estado_sig;
  captura_t   captura;
  logic [2:0] cuenta;
  logic [7:0] palabra_q;
  logic [7:0] codigo;
  logic       aceptar;
  logic       palabra_valida_q;
  logic       tx_serial_q;
  logic       tx_activo_q;
  logic       hecho_q;

  // Codeword layout: {g0, w3, w2, w1, p2, w0, p1, p0}
  always_comb begin
    codigo    = 8'h00;
    codigo[2] = captura.datos[0];
    codigo[4] = captura.datos[1];
    codigo[5] = captura.datos[2];
    codigo[6] = captura.datos[3];
    codigo[0] = captura.datos[0] ^ captura.datos[1] ^ captura.datos[3];
    codigo[1] = captura.datos[0] ^ captura.datos[2] ^ captura.datos[3];
    codigo[3] = captura.datos[1] ^ captura.datos[2] ^ captura.datos[3];
    codigo[7] = ^codigo[6:0];
  end

  assign bus.listo_out = (estado == IDLE);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      estado <= IDLE;
    end else begin
      estado <= estado_sig;
    end
  end

  // Next-state logic
  always_comb begin
    estado_sig = estado;
    aceptar    = 1'b0;
    case (estado)
      IDLE: begin
        if (bus.valido_in) begin
          aceptar    = 1'b1;
          estado_sig = CODIFICA;
        end
      end
      CODIFICA:  estado_sig = TRANSMITE;
      TRANSMITE: if (cuenta == 3'd7) estado_sig = FIN;
      FIN:       estado_sig = IDLE;
      default:   estado_sig = IDLE;
    endcase
  end

  // Datapath. Every output is registered from the current state, so the serial
  // stream and hecho trail the FSM by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      captura          <= '0;
      cuenta           <= 3'd0;
      palabra_q        <= 8'h00;
      palabra_valida_q <= 1'b0;
      tx_serial_q      <= 1'b0;
      tx_activo_q      <= 1'b0;
      hecho_q          <= 1'b0;
    end else begin
      palabra_valida_q <= 1'b0;
      tx_serial_q      <= 1'b0;
      tx_activo_q      <= 1'b0;
      hecho_q          <= 1'b0;

      if (aceptar) begin
        captura.datos   <= bus.datos_in;
        captura.mascara <= bus.mascara_error;
      end

      case (estado)
        CODIFICA: begin
          // Mask is applied unmodified, so multi-bit errors pass straight through.
          palabra_q        <= codigo ^ captura.mascara;
          palabra_valida_q <= 1'b1;
          cuenta           <= 3'd0;
        end
        TRANSMITE: begin
          tx_serial_q <= palabra_q[cuenta];
          tx_activo_q <= 1'b1;
          cuenta      <= cuenta + 3'd1;
        end
        FIN: begin
          hecho_q <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.palabra_out    = palabra_q;
  assign bus.palabra_valida = palabra_valida_q;
  assign bus.tx_serial      = tx_serial_q;
  assign bus.tx_activo      = tx_activo_q;
  assign bus.hecho          = hecho_q;

endmodule

// File: tb/tb_codificador_hamming_tx.sv
// Purpose: self-checking bench for codificador_hamming_tx (transaction model + directed vectors).
// Latency: model expects codeword 1 edge, serial bits 2..9 edges, hecho 10 edges after acceptance.
// Backpressure: model accepts only when its own notion of the FSM is idle.
module tb_codificador_hamming_tx;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  codificador_hamming_tx_if bus ();

  codificador_hamming_tx dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", nm, got, want, $time);
    end
  endtask

  task automatic tmo(input string nm);
    total++;
    bad++;
    $display("FAIL %s timeout at %0t", nm, $time);
  endtask

  // Classic Hamming construction: 1-based positions 1,2,4 are parity, the rest
  // carry data in order; parity j covers every position with bit j set.
  // Bit 7 tops up to even overall parity.
  function automatic logic [7:0] hamming(input logic [3:0] w);
    logic [7:0] c;
    logic       par;
    int         k;
    c = 8'h00;
    k = 0;
    for (int pos = 1; pos <= 7; pos++) begin
      if (pos != 1 && pos != 2 && pos != 4) begin
        c[pos-1] = w[k];
        k++;
      end
    end
    for (int j = 0; j < 3; j++) begin
      par = 1'b0;
      for (int pos = 1; pos <= 7; pos++)
        if (((pos >> j) & 1) == 1 && pos != (1 << j)) par ^= c[pos-1];
      c[(1 << j) - 1] = par;
    end
    c[7] = ^c[6:0];
    return c;
  endfunction

  // ---------------- transaction model ----------------
  int         edge_n = 0;
  bit         act    = 1'b0;
  int         acc    = 0;
  logic [7:0] mword  = 8'h00;
  logic [7:0] pal_hold = 8'h00;

  always @(posedge clk) begin
    edge_n++;
    if (rst) begin
      act      = 1'b0;
      pal_hold = 8'h00;
    end else begin
      if ((!act || (edge_n - acc) >= 11) && bus.valido_in) begin
        act   = 1'b1;
        acc   = edge_n;
        mword = hamming(bus.datos_in) ^ bus.mascara_error;
      end
      if (act && (edge_n - acc) == 1) pal_hold = mword;
    end
  end

  // One compare per cycle of every output against the model.
  always @(negedge clk) begin
    int          d;
    logic [12:0] want;
    logic [12:0] got;
    if (edge_n > 0) begin
      d = act ? (edge_n - acc) : 1000;
      want = {(!act || d >= 10),
              pal_hold,
              (act && d == 1),
              ((act && d >= 2 && d <= 9) ? mword[d-2] : 1'b0),
              (act && d >= 2 && d <= 9),
              (act && d == 10)};
      got  = {bus.listo_out, bus.palabra_out, bus.palabra_valida,
              bus.tx_serial, bus.tx_activo, bus.hecho};
      chk("ciclo", 32'(got), 32'(want));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic wait_listo(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (bus.listo_out) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic send(input logic [3:0] d, input logic [7:0] m,
                      input logic [7:0] want, input string nm);
    bit         ok;
    int         n;
    logic [7:0] sr;
    wait_listo(ok);
    if (!ok) begin
      tmo({nm, "_listo"});
      return;
    end
    bus.datos_in      = d;
    bus.mascara_error = m;
    bus.valido_in     = 1'b1;
    @(negedge clk);
    bus.valido_in = 1'b0;
    ok = 1'b0;
    for (n = 1; n <= 5; n++) begin
      @(negedge clk);
      if (bus.palabra_valida) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      tmo({nm, "_pv"});
      return;
    end
    chk({nm, "_lat"}, n, 1);
    chk({nm, "_word"}, 32'(bus.palabra_out), 32'(want));
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      sr[i] = bus.tx_serial;
    end
    chk({nm, "_serie"}, 32'(sr), 32'(want));
    @(negedge clk);
    chk({nm, "_hecho9"}, 32'(bus.hecho), 1);
  endtask

  initial begin
    bit         ok;
    int         c;
    int         np;
    int         k;
    int         t[2];
    logic [7:0] w[2];

    total = 0;
    bad   = 0;
    rst               = 1'b1;
    bus.valido_in     = 1'b1;          // must not be taken during reset
    bus.datos_in      = 4'b1011;
    bus.mascara_error = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_listo", 32'(bus.listo_out), 1);
    chk("rst_pal", 32'(bus.palabra_out), 0);
    chk("rst_pv", 32'(bus.palabra_valida), 0);
    bus.valido_in = 1'b0;
    rst           = 1'b0;
    @(negedge clk);
    chk("post_rst_listo", 32'(bus.listo_out), 1);

    // Hand-computed codewords
    send(4'b1011, 8'h00, 8'h55, "w1011");
    send(4'h0,    8'h00, 8'h00, "w0");
    send(4'hF,    8'h00, 8'hFF, "wF");
    send(4'h1,    8'h00, 8'h87, "w1");
    send(4'b1011, 8'h04, 8'h51, "err1");
    send(4'b1011, 8'h81, 8'hD4, "err2");

    // Exhaustive nibbles, overall parity must be even
    for (int n = 0; n < 16; n++) begin
      send(4'(n), 8'h00, hamming(4'(n)), "nib");
      chk("paridad", 32'(^bus.palabra_out), 0);
    end

    // Back-to-back with valido_in held; data changes mid-transmission
    wait_listo(ok);
    if (!ok) tmo("b2b_listo");
    bus.datos_in      = 4'h1;
    bus.mascara_error = 8'h00;
    bus.valido_in     = 1'b1;
    np = 0;
    for (c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 4) bus.datos_in = 4'hF;
      if (bus.palabra_valida) begin
        t[np] = c;
        w[np] = bus.palabra_out;
        np++;
        if (np == 2) break;
      end
    end
    bus.valido_in = 1'b0;
    if (np != 2) tmo("b2b_pv");
    else begin
      chk("b2b_gap", t[1] - t[0], 11);
      chk("b2b_w0", 32'(w[0]), 32'h87);
      chk("b2b_w1", 32'(w[1]), 32'hFF);
    end

    // valido_in held through the busy phase with different data: no second word
    wait_listo(ok);
    if (!ok) tmo("busy_listo");
    bus.datos_in      = 4'b1011;
    bus.mascara_error = 8'h00;
    bus.valido_in     = 1'b1;
    np = 0;
    for (c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) begin
        bus.datos_in      = 4'hF;
        bus.mascara_error = 8'hFF;
      end
      if (c == 9) bus.valido_in = 1'b0;
      if (c >= 1 && c <= 9) chk("busy_listo0", 32'(bus.listo_out), 0);
      if (bus.palabra_valida) begin
        if (np == 0) chk("busy_word", 32'(bus.palabra_out), 32'h55);
        np++;
      end
    end
    bus.valido_in = 1'b0;
    chk("busy_npv", np, 1);

    // Reset at serial bit 4
    wait_listo(ok);
    if (!ok) tmo("rstmid_listo");
    bus.datos_in      = 4'b1011;
    bus.mascara_error = 8'h00;
    bus.valido_in     = 1'b1;
    @(negedge clk);
    bus.valido_in = 1'b0;
    k  = 0;
    ok = 1'b0;
    for (c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.tx_activo) k++;
      if (k == 5) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) tmo("rstmid_bit4");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstmid_outs", 32'({bus.palabra_out, bus.palabra_valida, bus.tx_serial,
                            bus.tx_activo, bus.hecho}), 0);
    chk("rstmid_listo", 32'(bus.listo_out), 1);
    k = 0;
    for (c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.hecho) k++;
    end
    chk("rstmid_nohecho", k, 0);
    send(4'b1011, 8'h00, 8'h55, "post_rstmid");

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
